// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared widths, constants and busy-FSM encoding for hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int unsigned c_TUSE_W = 2;

    // A tuse of 3 marks a source operand the instruction never reads.
    localparam logic [c_TUSE_W-1:0] TUSE_NONE = 2'd3;

    localparam int unsigned c_MULT_CYC_DEF = 5;
    localparam int unsigned c_DIV_CYC_DEF  = 10;

    localparam int unsigned c_ST_W    = 1;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 1'b0;
    localparam logic [c_ST_W-1:0] c_ST_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/md_busy_fsm.sv
// ============================================================================
//  Module      : md_busy_fsm
//  Description : HI/LO busy tracker; counts down the mult/div latency after issue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYC = c_MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = c_DIV_CYC_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic e_start,
    input  logic e_div,
    output logic md_busy
);

    localparam int unsigned c_MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned c_CNT_W   = $clog2(c_MAX_CYC) + 1;

    localparam logic [c_CNT_W-1:0] c_MULT_LD = c_CNT_W'(MULT_CYC);
    localparam logic [c_CNT_W-1:0] c_DIV_LD  = c_CNT_W'(DIV_CYC);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // New issues are only accepted from IDLE; a start seen while BUSY is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (e_start) begin
                    w_state_nxt = c_ST_BUSY;
                    w_cnt_nxt   = e_div ? c_DIV_LD : c_MULT_LD;
                end
            end
            c_ST_BUSY: begin
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign md_busy = (r_state == c_ST_BUSY);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline stall unit (tuse/tnew + HI/LO busy); optional stall
//                performance counter enabled by macro HAZ_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYC = c_MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = c_DIV_CYC_DEF
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [4:0]          d_rs,
    input  logic [4:0]          d_rt,
    input  logic [c_TUSE_W-1:0] d_tuse_rs,
    input  logic [c_TUSE_W-1:0] d_tuse_rt,
    input  logic                d_md,
    input  logic [4:0]          e_wa,
    input  logic [4:0]          m_wa,
    input  logic [c_TUSE_W-1:0] e_tnew,
    input  logic [c_TUSE_W-1:0] m_tnew,
    input  logic                e_start,
    input  logic                e_div,
    output logic                pc_en,
    output logic                fd_en,
    output logic                de_clr,
    output logic                md_busy,
    output logic [31:0]         stall_cnt
);

    logic w_e_hit_rs, w_m_hit_rs, w_e_hit_rt, w_m_hit_rt;
    logic w_rs_stall, w_rt_stall, w_md_stall, w_stall;

    // A producer still too far from its result for the consumer's deadline forces a stall.
    assign w_e_hit_rs = (e_wa == d_rs) && (e_wa != 5'd0) && (e_tnew > d_tuse_rs);
    assign w_m_hit_rs = (m_wa == d_rs) && (m_wa != 5'd0) && (m_tnew > d_tuse_rs);
    assign w_e_hit_rt = (e_wa == d_rt) && (e_wa != 5'd0) && (e_tnew > d_tuse_rt);
    assign w_m_hit_rt = (m_wa == d_rt) && (m_wa != 5'd0) && (m_tnew > d_tuse_rt);

    assign w_rs_stall = (d_tuse_rs != TUSE_NONE) && (w_e_hit_rs || w_m_hit_rs);
    assign w_rt_stall = (d_tuse_rt != TUSE_NONE) && (w_e_hit_rt || w_m_hit_rt);
    assign w_md_stall = d_md && (md_busy || e_start);
    assign w_stall    = w_rs_stall || w_rt_stall || w_md_stall;

    assign pc_en  = ~w_stall;
    assign fd_en  = ~w_stall;
    assign de_clr = w_stall;

    md_busy_fsm #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_fsm (
        .clk     (clk),
        .clr     (clr),
        .e_start (e_start),
        .e_div   (e_div),
        .md_busy (md_busy)
    );

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_stall_cnt <= 32'h0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'h1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  d_rs, d_rt, e_wa, m_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_md, e_start, e_div;
    logic        pc_en, fd_en, de_clr, md_busy;
    logic [31:0] stall_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_left  = 0;
    logic [31:0] m_scnt  = 32'h0;

    hazard_ctrl #(
        .MULT_CYC (c_MULT),
        .DIV_CYC  (c_DIV)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_md      (d_md),
        .e_wa      (e_wa),
        .m_wa      (m_wa),
        .e_tnew    (e_tnew),
        .m_tnew    (m_tnew),
        .e_start   (e_start),
        .e_div     (e_div),
        .pc_en     (pc_en),
        .fd_en     (fd_en),
        .de_clr    (de_clr),
        .md_busy   (md_busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // A source waits while any in-flight writer of it needs more cycles than the source can wait.
    function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse);
        if (tuse == 2'd3 || r == 5'd0) return 1'b0;
        return (e_wa == r && e_tnew > tuse) || (m_wa == r && m_tnew > tuse);
    endfunction

    function automatic logic exp_stall();
        return src_stall(d_rs, d_tuse_rs) || src_stall(d_rt, d_tuse_rt) ||
               (d_md && (m_left > 0 || e_start));
    endfunction

    task automatic check_comb(input string tag);
        logic s;
        s = exp_stall();
        check(tag, {29'h0, pc_en, fd_en, de_clr}, {29'h0, ~s, ~s, s});
    endtask

    // One clock: advance the model with the pre-edge inputs, then compare registered outputs.
    task automatic tick();
        logic s, st, dv, cl;
        s  = exp_stall();
        st = e_start;
        dv = e_div;
        cl = clr;
        @(posedge clk);
        if (cl) begin
            m_left = 0;
            m_scnt = 32'h0;
        end else begin
            if (m_left > 0) m_left--;
            else if (st) m_left = dv ? c_DIV : c_MULT;
`ifdef HAZ_PERF_CNT_EN
            if (s) m_scnt++;
`endif
        end
        #1;
        check("md_busy", {31'h0, md_busy}, {31'h0, m_left > 0});
        check("stall_cnt", stall_cnt, m_scnt);
    endtask

    task automatic idle_inputs();
        d_rs = 5'd0; d_rt = 5'd0; e_wa = 5'd0; m_wa = 5'd0;
        d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; e_tnew = 2'd0; m_tnew = 2'd0;
        d_md = 1'b0; e_start = 1'b0; e_div = 1'b0;
    endtask

    int cnt;

    initial begin
        idle_inputs();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        #1;
        check("reset_busy", {31'h0, md_busy}, 32'h0);
        check("reset_scnt", stall_cnt, 32'h0);
        check_comb("reset_comb");

        d_rs = 5'd8; d_tuse_rs = 2'd0; e_wa = 5'd8; e_tnew = 2'd1;
        #1;
        check("e_fwd_stall", {29'h0, pc_en, fd_en, de_clr}, 32'h1);
        tick();

        idle_inputs();
        d_rs = 5'd8; d_tuse_rs = 2'd1; m_wa = 5'd8; m_tnew = 2'd1;
        #1;
        check("m_ready_nostall", {31'h0, de_clr}, 32'h0);
        idle_inputs();
        d_rs = 5'd0; d_tuse_rs = 2'd0; e_wa = 5'd0; e_tnew = 2'd2;
        #1;
        check("r0_nostall", {31'h0, de_clr}, 32'h0);
        tick();
        idle_inputs();

        for (int k = 0; k < 2; k++) begin
            e_start = 1'b1; e_div = (k == 1);
            tick();
            e_start = 1'b0;
            cnt = 0;
            for (int i = 0; i < 15; i++) begin
                if (md_busy) cnt++;
                tick();
            end
            check(k == 0 ? "mult_len" : "div_len", cnt, k == 0 ? c_MULT : c_DIV);
        end

        d_md = 1'b1; e_start = 1'b1; e_div = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (de_clr) cnt++;
            tick();
            e_start = 1'b0;
        end
        check("md_stall_len", cnt, 11);
        idle_inputs();

        e_start = 1'b1; e_div = 1'b1;
        tick();
        e_start = 1'b0;
        tick(); tick(); tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_abort", {31'h0, md_busy}, 32'h0);
        e_start = 1'b1; e_div = 1'b0;
        tick();
        check("reissue", {31'h0, md_busy}, 32'h1);
        e_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        clr = 1'b1;
        tick();
        clr = 1'b0;
        d_rs = 5'd8; d_tuse_rs = 2'd0; e_wa = 5'd8; e_tnew = 2'd1;
        for (int i = 0; i < 7; i++) tick();
        idle_inputs();
        tick();
`ifdef HAZ_PERF_CNT_EN
        check("perf_7", stall_cnt, 32'd7);
`else
        check("perf_off", stall_cnt, 32'd0);
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("perf_clr", stall_cnt, 32'd0);

        for (int i = 0; i < 400; i++) begin
            d_rs      = 5'($urandom_range(0, 3));
            d_rt      = 5'($urandom_range(0, 3));
            e_wa      = 5'($urandom_range(0, 3));
            m_wa      = 5'($urandom_range(0, 3));
            d_tuse_rs = 2'($urandom_range(0, 3));
            d_tuse_rt = 2'($urandom_range(0, 3));
            e_tnew    = 2'($urandom_range(0, 3));
            m_tnew    = 2'($urandom_range(0, 3));
            d_md      = ($urandom_range(0, 3) == 0);
            e_start   = ($urandom_range(0, 5) == 0);
            e_div     = $urandom_range(0, 1) == 1;
            clr       = ($urandom_range(0, 49) == 0);
            #1;
            check_comb("rand_comb");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
